// File: rtl/decode_cycle_if.sv
// Bundle of the decode stage's F/D inputs, writeback port, D/E outputs and sp.
// The master modport is the surrounding pipeline, and the slave modport is decode_cycle.
interface decode_cycle_if;
  logic [18:0] instrD;
  logic [18:0] pcD;
  logic [18:0] pcplus4D;
  logic        flushE;
  logic        regwriteW;
  logic [3:0]  rdW;
  logic [18:0] resultW;
  logic [18:0] rd1E;
  logic [18:0] rd2E;
  logic [18:0] immextE;
  logic [18:0] pcE;
  logic [18:0] pcplus4E;
  logic [3:0]  rs1E;
  logic [3:0]  rs2E;
  logic [3:0]  rdE;
  logic        regwriteE;
  logic        memwriteE;
  logic        alusrcE;
  logic        branchE;
  logic [1:0]  resultsrcE;
  logic [3:0]  alucontrolE;
  logic [1:0]  jumptypeE;
  logic [18:0] sp;

  modport master (
    output instrD, pcD, pcplus4D, flushE, regwriteW, rdW, resultW,
    input  rd1E, rd2E, immextE, pcE, pcplus4E, rs1E, rs2E, rdE,
    input  regwriteE, memwriteE, alusrcE, branchE, resultsrcE, alucontrolE, jumptypeE, sp
  );

  modport slave (
    input  instrD, pcD, pcplus4D, flushE, regwriteW, rdW, resultW,
    output rd1E, rd2E, immextE, pcE, pcplus4E, rs1E, rs2E, rdE,
    output regwriteE, memwriteE, alusrcE, branchE, resultsrcE, alucontrolE, jumptypeE, sp
  );
endinterface

// File: rtl/decode_cycle.sv
// Decode stage of the 19-bit CPU: control decode, 16x19 register file, immediate extension, D/E register.
// Optional macro DECODE_BYPASS_EN forwards a same-cycle writeback onto the read ports and onto sp.
module decode_cycle (
  input logic         clk,
  input logic         rst,
  decode_cycle_if.slave bus
);

  function automatic logic [18:0] sext6(input logic [5:0] v);
    return {{13{v[5]}}, v};
  endfunction

  function automatic logic [18:0] sext14(input logic [13:0] v);
    return {{5{v[13]}}, v};
  endfunction

  logic [18:0] regs_r [16];

  logic [4:0]  opcode_s;
  logic [3:0]  rs1_idx_s;
  logic [3:0]  rs2_idx_s;
  logic [3:0]  rd_idx_s;
  logic [18:0] imm_s;
  logic        regwrite_s;
  logic        memwrite_s;
  logic        alusrc_s;
  logic        branch_s;
  logic [1:0]  resultsrc_s;
  logic [3:0]  alucontrol_s;
  logic [1:0]  jumptype_s;
  logic        use_jimm_s;
  logic        rs2_from_rd_s;
  logic        rd_link_s;
  logic        we_s;
  logic [18:0] rd1_s;
  logic [18:0] rd2_s;
  logic [18:0] sp_s;

  assign opcode_s = bus.instrD[18:14];
  // Reset takes priority over writeback, so the write enable is qualified by rst.
  assign we_s     = rst && bus.regwriteW && (bus.rdW != 4'd0);

  // Opcode to control-signal decode; unknown opcodes leave every enable low
  always_comb begin
    regwrite_s    = 1'b0;
    memwrite_s    = 1'b0;
    alusrc_s      = 1'b0;
    branch_s      = 1'b0;
    resultsrc_s   = 2'b00;
    alucontrol_s  = 4'b0000;
    jumptype_s    = 2'b00;
    use_jimm_s    = 1'b0;
    rs2_from_rd_s = 1'b0;
    rd_link_s     = 1'b0;
    case (opcode_s)
      5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b00101, 5'b00110, 5'b00111: begin
        regwrite_s   = 1'b1;
        alucontrol_s = opcode_s[3:0];
      end
      5'b01000: begin
        regwrite_s   = 1'b1;
        alusrc_s     = 1'b1;
        alucontrol_s = 4'b0001;
      end
      5'b01001: begin
        regwrite_s   = 1'b1;
        alusrc_s     = 1'b1;
        resultsrc_s  = 2'b01;
        alucontrol_s = 4'b0001;
      end
      5'b01010: begin
        memwrite_s    = 1'b1;
        alusrc_s      = 1'b1;
        alucontrol_s  = 4'b0001;
        rs2_from_rd_s = 1'b1;
      end
      5'b01011: begin
        branch_s     = 1'b1;
        alucontrol_s = 4'b0010;
      end
      5'b01100: begin
        jumptype_s = 2'b01;
        use_jimm_s = 1'b1;
      end
      5'b01101: begin
        jumptype_s  = 2'b01;
        use_jimm_s  = 1'b1;
        regwrite_s  = 1'b1;
        resultsrc_s = 2'b10;
        rd_link_s   = 1'b1;
      end
      5'b01110: begin
        jumptype_s = 2'b10;
      end
      default: begin
        regwrite_s = 1'b0;
      end
    endcase
  end

  // A store carries its data register in the rd field, and a call always links into r15.
  assign rs1_idx_s = bus.instrD[9:6];
  assign rs2_idx_s = rs2_from_rd_s ? bus.instrD[13:10] : bus.instrD[5:2];
  assign rd_idx_s  = rd_link_s ? 4'd15 : bus.instrD[13:10];
  assign imm_s     = use_jimm_s ? sext14(bus.instrD[13:0]) : sext6(bus.instrD[5:0]);

  // Read port 1 with r0 hard-wired to zero
  always_comb begin
    if (rs1_idx_s == 4'd0) begin
      rd1_s = 19'd0;
`ifdef DECODE_BYPASS_EN
    end else if (we_s && (bus.rdW == rs1_idx_s)) begin
      rd1_s = bus.resultW;
`endif
    end else begin
      rd1_s = regs_r[rs1_idx_s];
    end
  end

  // Read port 2 with r0 hard-wired to zero
  always_comb begin
    if (rs2_idx_s == 4'd0) begin
      rd2_s = 19'd0;
`ifdef DECODE_BYPASS_EN
    end else if (we_s && (bus.rdW == rs2_idx_s)) begin
      rd2_s = bus.resultW;
`endif
    end else begin
      rd2_s = regs_r[rs2_idx_s];
    end
  end

  // The link register r15 is exported as sp for the fetch PC mux.
  always_comb begin
`ifdef DECODE_BYPASS_EN
    if (we_s && (bus.rdW == 4'd15)) begin
      sp_s = bus.resultW;
    end else begin
      sp_s = regs_r[15];
    end
`else
    sp_s = regs_r[15];
`endif
  end

  assign bus.sp = sp_s;

  // Register file write port driven by writeback
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= 19'd0;
      end
    end else if (we_s) begin
      regs_r[bus.rdW] <= bus.resultW;
    end
  end

  // D/E pipeline register; a flush loads an all-zero bubble
  always_ff @(posedge clk) begin
    if (!rst || bus.flushE) begin
      bus.rd1E        <= 19'd0;
      bus.rd2E        <= 19'd0;
      bus.immextE     <= 19'd0;
      bus.pcE         <= 19'd0;
      bus.pcplus4E    <= 19'd0;
      bus.rs1E        <= 4'd0;
      bus.rs2E        <= 4'd0;
      bus.rdE         <= 4'd0;
      bus.regwriteE   <= 1'b0;
      bus.memwriteE   <= 1'b0;
      bus.alusrcE     <= 1'b0;
      bus.branchE     <= 1'b0;
      bus.resultsrcE  <= 2'b00;
      bus.alucontrolE <= 4'b0000;
      bus.jumptypeE   <= 2'b00;
    end else begin
      bus.rd1E        <= rd1_s;
      bus.rd2E        <= rd2_s;
      bus.immextE     <= imm_s;
      bus.pcE         <= bus.pcD;
      bus.pcplus4E    <= bus.pcplus4D;
      bus.rs1E        <= rs1_idx_s;
      bus.rs2E        <= rs2_idx_s;
      bus.rdE         <= rd_idx_s;
      bus.regwriteE   <= regwrite_s;
      bus.memwriteE   <= memwrite_s;
      bus.alusrcE     <= alusrc_s;
      bus.branchE     <= branch_s;
      bus.resultsrcE  <= resultsrc_s;
      bus.alucontrolE <= alucontrol_s;
      bus.jumptypeE   <= jumptype_s;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: a directed vector table for the listed scenarios, then random instructions
// checked against an instruction-level reference model; it honours DECODE_BYPASS_EN.
module tb_decode_cycle;

  logic clk;
  logic rst;
  decode_cycle_if bus ();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [18:0] instr;
    logic [18:0] pcp4;
    logic        flush;
    logic        wr;
    logic [3:0]  rdw;
    logic [18:0] resw;
    logic [18:0] e_rd1;
    logic [18:0] e_rd2;
    logic [18:0] e_imm;
    logic [3:0]  e_rd;
    logic [11:0] e_ctl;
    logic [18:0] e_sp;
  } vec_t;

  localparam logic [18:0] ADD131 = {5'b00001, 4'd1, 4'd3, 4'd3, 2'b00};
  localparam logic [18:0] ADDI_M1 = {5'b01000, 4'd2, 4'd0, 6'b111111};
  localparam logic [18:0] ADD650 = {5'b00001, 4'd6, 4'd5, 4'd0, 2'b00};
  localparam logic [18:0] CALL_I = {5'b01101, 14'h3FF0};
  localparam logic [18:0] RET_I  = {5'b01110, 14'h0000};
  localparam logic [18:0] LD_I   = {5'b01001, 4'd1, 4'd3, 6'b000010};
  localparam logic [18:0] ADD100 = {5'b00001, 4'd1, 4'd0, 4'd0, 2'b00};
  localparam logic [18:0] ST_I   = {5'b01010, 4'd3, 4'd1, 6'b111110};
  localparam logic [18:0] BEQ_I  = {5'b01011, 4'd0, 4'd3, 4'd3, 2'b01};
`ifdef DECODE_BYPASS_EN
  localparam logic [18:0] SAME_CYCLE_RD1 = 19'd7;
`else
  localparam logic [18:0] SAME_CYCLE_RD1 = 19'd0;
`endif

  logic [18:0] ref_regs [16];
  int n_checks;
  int n_fail;
  int step_no;

  function automatic vec_t mkv(logic r, logic [18:0] ins, logic [18:0] p4, logic fl, logic w,
                               logic [3:0] rw, logic [18:0] res, logic [18:0] a, logic [18:0] b,
                               logic [18:0] im, logic [3:0] d, logic [11:0] c, logic [18:0] s);
    vec_t v;
    v.rst = r; v.instr = ins; v.pcp4 = p4; v.flush = fl; v.wr = w; v.rdw = rw; v.resw = res;
    v.e_rd1 = a; v.e_rd2 = b; v.e_imm = im; v.e_rd = d; v.e_ctl = c; v.e_sp = s;
    return v;
  endfunction

  // The writeback takes effect only outside reset and never targets r0.
  function automatic logic eff_write(logic r, logic w, logic [3:0] rw);
    return r && w && (rw != 4'd0);
  endfunction

  function automatic logic [18:0] ref_read(logic [3:0] idx, logic r, logic w, logic [3:0] rw,
                                           logic [18:0] res);
    if (idx == 4'd0) return 19'd0;
`ifdef DECODE_BYPASS_EN
    if (eff_write(r, w, rw) && rw == idx) return res;
`endif
    return ref_regs[idx];
  endfunction

  // Expected D/E contents computed at the instruction level.
  function automatic logic [118:0] model_e(logic r, logic [18:0] ins, logic [18:0] pc,
                                           logic [18:0] p4, logic fl, logic w, logic [3:0] rw,
                                           logic [18:0] res);
    int op;
    logic rg, mw, as, br;
    logic [1:0] rs, jt;
    logic [3:0] alu, i1, i2, d;
    logic [18:0] imm;
    if (!r || fl) return '0;
    op = int'(ins[18:14]);
    rg = 1'b0; mw = 1'b0; as = 1'b0; br = 1'b0; rs = 2'd0; jt = 2'd0; alu = 4'd0;
    i1 = ins[9:6];
    i2 = (op == 10) ? ins[13:10] : ins[5:2];
    d  = (op == 13) ? 4'd15 : ins[13:10];
    if (op == 12 || op == 13)
      imm = ins[13] ? 19'(ins[13:0]) - 19'd16384 : 19'(ins[13:0]);
    else
      imm = ins[5] ? 19'(ins[5:0]) - 19'd64 : 19'(ins[5:0]);
    if (op >= 1 && op <= 7) begin rg = 1'b1; alu = 4'(op); end
    else if (op == 8)  begin rg = 1'b1; as = 1'b1; alu = 4'd1; end
    else if (op == 9)  begin rg = 1'b1; as = 1'b1; alu = 4'd1; rs = 2'd1; end
    else if (op == 10) begin mw = 1'b1; as = 1'b1; alu = 4'd1; end
    else if (op == 11) begin br = 1'b1; alu = 4'd2; end
    else if (op == 12) begin jt = 2'd1; end
    else if (op == 13) begin jt = 2'd1; rg = 1'b1; rs = 2'd2; end
    else if (op == 14) begin jt = 2'd2; end
    return {ref_read(i1, r, w, rw, res), ref_read(i2, r, w, rw, res), imm, pc, p4, i1, i2, d,
            rg, mw, as, br, rs, alu, jt};
  endfunction

  function automatic logic [18:0] model_sp();
`ifdef DECODE_BYPASS_EN
    if (eff_write(rst, bus.regwriteW, bus.rdW) && bus.rdW == 4'd15) return bus.resultW;
`endif
    return ref_regs[15];
  endfunction

  function automatic logic [118:0] dut_e();
    return {bus.rd1E, bus.rd2E, bus.immextE, bus.pcE, bus.pcplus4E, bus.rs1E, bus.rs2E, bus.rdE,
            bus.regwriteE, bus.memwriteE, bus.alusrcE, bus.branchE, bus.resultsrcE,
            bus.alucontrolE, bus.jumptypeE};
  endfunction

  task automatic chk(string name, logic [118:0] act, logic [118:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
    end
  endtask

  // Apply inputs, clock once, advance the model, leave the outputs ready to sample.
  task automatic apply(logic r, logic [18:0] ins, logic [18:0] pc, logic [18:0] p4, logic fl,
                       logic w, logic [3:0] rw, logic [18:0] res, output logic [118:0] exp);
    rst = r; bus.instrD = ins; bus.pcD = pc; bus.pcplus4D = p4; bus.flushE = fl;
    bus.regwriteW = w; bus.rdW = rw; bus.resultW = res;
    exp = model_e(r, ins, pc, p4, fl, w, rw, res);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 16; i++) ref_regs[i] = 19'd0;
    end else if (eff_write(r, w, rw)) begin
      ref_regs[rw] = res;
    end
    #1;
  endtask

  initial begin
    vec_t vecs[18];
    logic [118:0] exp;
    logic [18:0] ins, pc;
    n_checks = 0; n_fail = 0; step_no = 0;
    for (int i = 0; i < 16; i++) ref_regs[i] = 19'd0;
    rst = 1'b0; bus.instrD = 19'd0; bus.pcD = 19'd0; bus.pcplus4D = 19'd0; bus.flushE = 1'b0;
    bus.regwriteW = 1'b0; bus.rdW = 4'd0; bus.resultW = 19'd0;

    //             rst  instr    pcp4    fl    wr    rdW    resW       rd1E            rd2E      immE        rdE    ctl      sp
    vecs[0]  = mkv(1'b0, ADD131,  19'd0,  1'b0, 1'b1, 4'd3,  19'd5,   19'd0,          19'd0,   19'd0,      4'd0,  12'h000, 19'd0);
    vecs[1]  = mkv(1'b0, ADD131,  19'd0,  1'b0, 1'b1, 4'd3,  19'd5,   19'd0,          19'd0,   19'd0,      4'd0,  12'h000, 19'd0);
    vecs[2]  = mkv(1'b1, 19'd0,   19'd0,  1'b0, 1'b1, 4'd3,  19'd100, 19'd0,          19'd0,   19'd0,      4'd0,  12'h000, 19'd0);
    vecs[3]  = mkv(1'b1, ADD131,  19'd0,  1'b0, 1'b0, 4'd0,  19'd0,   19'd100,        19'd100, 19'd12,     4'd1,  12'h804, 19'd0);
    vecs[4]  = mkv(1'b1, ADDI_M1, 19'd0,  1'b0, 1'b0, 4'd0,  19'd0,   19'd0,          19'd0,   19'h7FFFF,  4'd2,  12'hA04, 19'd0);
    vecs[5]  = mkv(1'b1, ADD650,  19'd0,  1'b0, 1'b1, 4'd5,  19'd7,   SAME_CYCLE_RD1, 19'd0,   19'd0,      4'd6,  12'h804, 19'd0);
    vecs[6]  = mkv(1'b1, ADD650,  19'd0,  1'b0, 1'b0, 4'd0,  19'd0,   19'd7,          19'd0,   19'd0,      4'd6,  12'h804, 19'd0);
    vecs[7]  = mkv(1'b1, CALL_I,  19'd40, 1'b0, 1'b0, 4'd0,  19'd0,   19'd0,          19'd0,   19'h7FFF0,  4'd15, 12'h881, 19'd0);
    vecs[8]  = mkv(1'b1, 19'd0,   19'd0,  1'b0, 1'b1, 4'd15, 19'd40,  19'd0,          19'd0,   19'd0,      4'd0,  12'h000, 19'd40);
    vecs[9]  = mkv(1'b1, RET_I,   19'd0,  1'b0, 1'b0, 4'd0,  19'd0,   19'd0,          19'd0,   19'd0,      4'd0,  12'h002, 19'd40);
    vecs[10] = mkv(1'b1, LD_I,    19'd0,  1'b1, 1'b0, 4'd0,  19'd0,   19'd0,          19'd0,   19'd0,      4'd0,  12'h000, 19'd40);
    vecs[11] = mkv(1'b1, ADD100,  19'd0,  1'b0, 1'b1, 4'd0,  19'd123, 19'd0,          19'd0,   19'd0,      4'd1,  12'h804, 19'd40);
    vecs[12] = mkv(1'b1, ADD100,  19'd0,  1'b0, 1'b0, 4'd0,  19'd0,   19'd0,          19'd0,   19'd0,      4'd1,  12'h804, 19'd40);
    vecs[13] = mkv(1'b1, LD_I,    19'd0,  1'b0, 1'b0, 4'd0,  19'd0,   19'd100,        19'd0,   19'd2,      4'd1,  12'hA44, 19'd40);
    vecs[14] = mkv(1'b1, ST_I,    19'd0,  1'b0, 1'b0, 4'd0,  19'd0,   19'd0,          19'd100, 19'h7FFFE,  4'd3,  12'h604, 19'd40);
    vecs[15] = mkv(1'b1, BEQ_I,   19'd0,  1'b0, 1'b0, 4'd0,  19'd0,   19'd100,        19'd100, 19'd13,     4'd0,  12'h108, 19'd40);
    vecs[16] = mkv(1'b0, ADD131,  19'd0,  1'b0, 1'b1, 4'd4,  19'd9,   19'd0,          19'd0,   19'd0,      4'd0,  12'h000, 19'd0);
    vecs[17] = mkv(1'b1, ADD131,  19'd0,  1'b0, 1'b0, 4'd0,  19'd0,   19'd0,          19'd0,   19'd12,     4'd1,  12'h804, 19'd0);

    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      step_no = k;
      pc = vecs[k].pcp4 - 19'd4;
      apply(vecs[k].rst, vecs[k].instr, pc, vecs[k].pcp4, vecs[k].flush, vecs[k].wr,
            vecs[k].rdw, vecs[k].resw, exp);
      chk("rd1E", 119'(bus.rd1E), 119'(vecs[k].e_rd1));
      chk("rd2E", 119'(bus.rd2E), 119'(vecs[k].e_rd2));
      chk("immextE", 119'(bus.immextE), 119'(vecs[k].e_imm));
      chk("rdE", 119'(bus.rdE), 119'(vecs[k].e_rd));
      chk("ctl", 119'({bus.regwriteE, bus.memwriteE, bus.alusrcE, bus.branchE, bus.resultsrcE,
                        bus.alucontrolE, bus.jumptypeE}), 119'(vecs[k].e_ctl));
      chk("sp", 119'(bus.sp), 119'(vecs[k].e_sp));
      chk("model_e", dut_e(), exp);
    end

    // Randomized instruction stream with occasional flushes and resets.
    for (int k = 0; k < 400; k++) begin
      step_no = 100 + k;
      ins = 19'($urandom());
      if ($urandom_range(0, 3) != 0) ins[18:14] = 5'($urandom_range(0, 14));
      pc = 19'($urandom());
      apply($urandom_range(0, 49) != 0, ins, pc, pc + 19'd4, $urandom_range(0, 9) == 0,
            1'($urandom()), 4'($urandom()), 19'($urandom()), exp);
      chk("rand_e", dut_e(), exp);
      chk("rand_sp", 119'(bus.sp), 119'(model_sp()));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
